serial_to_parallel_8: RTL
=========================

# serial_to_parallel_8

Collects a serial bit stream into parallel words: the other direction of the 8:1 bit-select mux path. Each accepted input bit is written into the bit position given by an internal write-index counter. After WIDTH bits, the block presents one WIDTH-bit word on a valid/ready output. It sits between a serial link front-end, for example a bit sampler, and word-oriented logic.

## Interface
- WIDTH, 8: word width. Must be a power of 2 and at least 2. IW = $clog2(WIDTH).
- LSB_FIRST, 1: 1 means the first accepted bit lands in data[0]; 0 means it lands in data[WIDTH-1].
- clk  input  1  clock; every register updates on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- flush  input  1  synchronous abort of the partially assembled word.
- s_bit  input  1  serial data bit.
- s_valid  input  1  s_bit is valid this cycle.
- s_ready  output  1  the block accepts s_bit this cycle.
- m_data  output  WIDTH  assembled word; registered.
- m_valid  output  1  m_data holds an unconsumed word.
- m_ready  input  1  the consumer takes m_data this cycle.
- bit_cnt  output  IW  number of bits already accepted into the current word.

## Operation
- Reset values: m_data = 0, m_valid = 0, bit_cnt = 0, assembly register = 0. s_ready = 1 once reset is released.
- Input transfer: a bit is accepted when s_valid && s_ready.
- Write position for an accepted bit:
  - LSB_FIRST = 1: position bit_cnt.
  - LSB_FIRST = 0: position WIDTH-1-bit_cnt.
- Bits not being written are held.
- bit_cnt increments by 1 per accepted bit. It wraps from WIDTH-1 to 0 on the accept that completes the word.
- Word completion: the accept occurs while bit_cnt == WIDTH-1.
  - On that edge, m_data loads the assembly register with the final bit merged in, and m_valid is set.
  - The assembly register does not need clearing, because every bit of the next word is overwritten.
- Output transfer: m_valid && m_ready.
  - m_valid clears on that edge unless a new word completes on the same edge. In that case m_valid stays 1 and m_data takes the new word.
- Backpressure: s_ready = !(bit_cnt == WIDTH-1 && m_valid && !m_ready) && !flush.
  - Bits 0..WIDTH-2 of the next word are always accepted while an output word is held.
  - Only the completing bit stalls.
  - s_ready is combinational from m_ready, m_valid, bit_cnt and flush.
- flush:
  - On the next edge, bit_cnt goes to 0 and the assembly register goes to 0.
  - m_valid and m_data are unaffected; a completed word is never discarded.
  - flush wins over a simultaneous s_valid: s_ready is 0, so the bit is not accepted.
- Stability: while m_valid && !m_ready, m_data and m_valid hold.
- States, encoded implicitly by bit_cnt and m_valid:
  - EMPTY: bit_cnt = 0, m_valid = 0.
  - COLLECT: bit_cnt > 0.
  - HOLD: m_valid = 1.
  - STALL: HOLD with bit_cnt == WIDTH-1 and !m_ready.
  - COLLECT and HOLD coexist.

## Timing
- Latency: if the last bit of a word is accepted at edge N, m_valid = 1 and m_data is valid from edge N through at least edge N+1.
- Throughput: 1 bit per cycle sustained when m_ready is held at 1; no bubble between words.
- Reset mid-operation: rst asserted at any time forces every register to its reset value immediately, with no clock required. A partial word is lost, and any held output word is lost.
- First accept after reset: s_valid at the first edge with rst low is accepted.
- No combinational path from s_bit or s_valid to any output. s_ready is the only combinational output.

## Test plan
- Reset: assert rst mid-simulation without a clock edge -> m_valid = 0, m_data = 0x00 and bit_cnt = 0 immediately; s_ready = 1 after release.
- LSB_FIRST = 1, m_ready = 1: feed bits 1,0,1,0,0,1,0,1 on consecutive cycles -> m_data = 0xA5 with m_valid high for exactly 1 cycle, one cycle after the 8th accept.
- LSB_FIRST = 0: the same bit sequence -> m_data = 0xA5 bit-reversed = 0xA5.
- LSB_FIRST = 0: a second word of bits 1,1,0,0,0,0,0,0 -> m_data = 0xC0.
- Backpressure, m_ready = 0:
  - Feed 15 bits -> first word (0x0F from bits 1,1,1,1,0,0,0,0) held stable, bit_cnt = 7, s_ready = 0.
  - Raise m_ready for 1 cycle -> s_ready = 1 that cycle, the 16th bit is accepted, and the second word appears the following cycle.
- Flush mid-word: accept 3 bits, then assert flush together with s_valid -> bit not accepted, bit_cnt = 0. The next 8 bits form a clean word, and an earlier held word is still delivered intact.
- Back-to-back with gaps: s_valid toggling randomly, 4 words 0x00, 0xFF, 0x3C, 0x81 -> exactly 4 output transfers, with values in order and no duplicates.

Source files
------------

// File: rtl/serial_to_parallel_8_if.sv
// Handshake bundle between a serial bit source, the deserializer and a word consumer.
// The slave modport is the deserializer's view; master is the driver side.
interface serial_to_parallel_8_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic             flush;
    logic             s_bit;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [IW-1:0]    bit_cnt;

    modport master (
        output flush, s_bit, s_valid, m_ready,
        input  s_ready, m_data, m_valid, bit_cnt
    );

    modport slave (
        input  flush, s_bit, s_valid, m_ready,
        output s_ready, m_data, m_valid, bit_cnt
    );
endinterface

// File: rtl/serial_to_parallel_8.sv
// Serial-to-parallel deserializer: packs accepted bits into WIDTH-bit words and
// presents each completed word on a valid/ready output with a one-word holding register.
//
// state   | meaning
// EMPTY   | bit_cnt = 0 and no output word held
// COLLECT | bit_cnt > 0, a partial word is being assembled
// HOLD    | m_valid = 1, a completed word waits for the consumer
// STALL   | HOLD with bit_cnt = WIDTH-1 and !m_ready; only the completing bit waits
module serial_to_parallel_8 #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_to_parallel_8_if.slave bus
);
    localparam int            IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] merged;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    pos;
    logic             valid_q, valid_d;
    logic             last, take, ready_c, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        last    = (cnt_q == LAST_IDX);
        take    = valid_q && bus.m_ready;
        ready_c = !(last && valid_q && !bus.m_ready) && !bus.flush;
        accept  = bus.s_valid && ready_c;
        pos     = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);

        merged      = asm_q;
        merged[pos] = bus.s_bit;

        asm_d   = asm_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (take) begin
            valid_d = 1'b0;
        end

        // flush only touches the partial word; a completed word is never dropped
        if (bus.flush) begin
            asm_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            asm_d = merged;
            if (last) begin
                cnt_d   = '0;
                data_d  = merged;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign bus.s_ready = ready_c;
    assign bus.m_data  = data_q;
    assign bus.m_valid = valid_q;
    assign bus.bit_cnt = cnt_q;
endmodule
